// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one serialized req/ready access to data memory at a time, stalling the pipeline.
// Optional bus-timeout abort is compiled in when LSU_TIMEOUT_EN is defined.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_i,
  input  logic [31:0] data2_i,
  input  logic        memr_i,
  input  logic        memw_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic        is_load_r;

  logic        acc_s;
  logic        misalign_s;
  logic        stall_s;
  logic        misalign_pulse_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b100:  load_extract = {24'h000000, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b101:  load_extract = {16'h0000, h};
      default: load_extract = rdata;
    endcase
  endfunction

  assign acc_s   = memr_i | memw_i;
  assign be_s    = lane_be(funct3_i, alu_i[1:0]);
  assign wdata_s = lane_wdata(funct3_i, data2_i);

  // Alignment decode: bytes never misalign, halfwords need bit 0 clear, words need [1:0] clear
  always_comb begin
    misalign_s = 1'b0;
    case (funct3_i[1:0])
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = alu_i[0];
      default: misalign_s = (alu_i[1:0] != 2'b00);
    endcase
  end

  // Stall and misalign are combinational so the pipeline freezes in the same cycle the access is seen
  always_comb begin
    stall_s          = 1'b0;
    misalign_pulse_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (acc_s) begin
          stall_s          = ~misalign_s;
          misalign_pulse_s = misalign_s;
        end else begin
          stall_s          = 1'b0;
          misalign_pulse_s = 1'b0;
        end
      end
      ST_BUSY: stall_s = 1'b1;
      default: stall_s = 1'b0;
    endcase
  end

  // Gated by rst_n so every output reads 0 while reset is held, even with an access on the inputs
  assign stall_o    = stall_s & rst_n;
  assign misalign_o = misalign_pulse_s & rst_n;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_r;
  logic          timeout_s;

  assign timeout_s = (state_r == ST_BUSY) && !dmem_ready_i && (cnt_r == CNT_LAST);
  assign timeout_o = timeout_s & rst_n;
`else
  assign timeout_o = 1'b0;
`endif

  // Access FSM with registered bus outputs and load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= 32'h0000_0000;
      dmem_be_o    <= 4'b0000;
      dmem_wdata_o <= 32'h0000_0000;
      load_data_o  <= 32'h0000_0000;
      f3_r         <= 3'b000;
      off_r        <= 2'b00;
      is_load_r    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_r        <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (acc_s && !misalign_s) begin
            state_r      <= ST_BUSY;
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= memw_i;
            dmem_addr_o  <= {alu_i[31:2], 2'b00};
            dmem_be_o    <= be_s;
            dmem_wdata_o <= wdata_s;
            f3_r         <= funct3_i;
            off_r        <= alu_i[1:0];
            is_load_r    <= ~memw_i;
`ifdef LSU_TIMEOUT_EN
            cnt_r        <= '0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // Ready wins over a terminal timeout count in the same cycle
          if (dmem_ready_i) begin
            dmem_req_o <= 1'b0;
            state_r    <= ST_DONE;
            if (is_load_r) begin
              load_data_o <= load_extract(f3_r, off_r, dmem_rdata_i);
            end else begin
              load_data_o <= load_data_o;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (timeout_s) begin
            dmem_req_o  <= 1'b0;
            load_data_o <= 32'h0000_0000;
            state_r     <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
`else
          else begin
            state_r <= ST_BUSY;
          end
`endif
        end
        // Inputs still describe the completed access here, so no new request
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the RISC-V pipeline.
- Sits directly downstream of the EX/MEM pipeline register. It consumes the registered ALU address, store data and memory-control bits, and runs a req/ready handshake with the data memory.
- Returns aligned, sign/zero-extended load data to the MEM/WB register.
- Stalls the pipeline while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in BUSY before abort (only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_i  in  32  effective address from EX/MEM ALU output.
- data2_i  in  32  store data from EX/MEM.
- memr_i  in  1  load request from EX/MEM.
- memw_i  in  1  store request from EX/MEM.
- funct3_i  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  word address, alu_i with bits [1:0] forced to 0.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_ready_i  in  1  memory accepted/completed the access this cycle.
- dmem_rdata_i  in  32  read word, valid when dmem_ready_i=1.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- load_data_o  out  32  extended load result to MEM/WB.
- misalign_o  out  1  misaligned-access pulse.
- timeout_o  out  1  bus timeout pulse (LSU_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset mid-access aborts immediately, drops dmem_req_o and discards the access.
- acc = memr_i | memw_i. If both are set, the store wins.
- Misaligned means one of:
  - halfword access with alu_i[0]=1;
  - word access with alu_i[1:0]!=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If acc and not misaligned: stall_o=1 combinationally; next state BUSY. Register dmem_req_o=1, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o.
  - If acc and misaligned: no request; misalign_o=1 for this cycle; stall_o=0; stay IDLE.
  - Otherwise stall_o=0.
- BUSY:
  - stall_o=1; bus outputs held stable.
  - On dmem_ready_i=1: dmem_req_o<=0. For a load, load_data_o<=extract(dmem_rdata_i). Next state DONE.
- DONE:
  - stall_o=0, so EX/MEM advances at this edge; next state IDLE.
  - No new request is issued in DONE, because the inputs still describe the completed access.
- Latency: minimum 3 cycles (IDLE-stall, BUSY with same-cycle ready, DONE), i.e. 2 stall cycles. Each extra wait cycle adds 1.
- load_data_o holds its value until the next completed load. Stores and misaligned accesses leave it unchanged.
- Load extract, with byte offset off = alu_i[1:0]:
  - byte = rdata[8*off+7 : 8*off];
  - half = rdata[16*off[1]+15 : 16*off[1]];
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store:
  - SB: be = 0001<<off; wdata = {4{data2_i[7:0]}}.
  - SH: be = 0011<<off; wdata = {2{data2_i[15:0]}}.
  - SW: be = 1111; wdata = data2_i.
- Loads drive be for the accessed lanes using the same rules.
- dmem_ready_i is ignored outside BUSY.
- Back-to-back accesses are fully serialized. The new access starts in the IDLE cycle after DONE.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ready.
  - When it reaches TIMEOUT_CYCLES with no ready: dmem_req_o<=0, timeout_o=1 for one cycle, next state DONE, load_data_o<=0.
  - Ready in the same cycle as the terminal count takes priority; no timeout.
- Undefined: no counter; BUSY waits indefinitely; timeout_o tied 0.

Test Plan:
- LW alu_i=0x100, ready on 1st BUSY cycle, rdata=0xDEADBEEF -> dmem_addr_o=0x100, be=1111; stall_o high 2 cycles; load_data_o=0xDEADBEEF in DONE.
- LB alu_i=0x103, rdata=0x80112233 -> be=1000, load_data_o=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU alu_i=0x102 -> 0x00008011.
- SH alu_i=0x202, data2_i=0x1234ABCD, ready delayed 3 cycles -> dmem_we_o=1, be=1100, wdata=0xABCDABCD held stable; stall_o high 5 cycles; load_data_o unchanged.
- LW alu_i=0x101 -> misalign_o=1 one cycle, dmem_req_o never asserts, stall_o=0.
- Load in BUSY, rst_n low for 1 cycle -> all outputs 0 asynchronously, state IDLE, no request after release until a new acc.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, ready never asserted -> timeout_o pulses on the 4th BUSY cycle, load_data_o=0, stall released next cycle.
